// File: rtl/operand_stage_r32i_pkg.sv
// Shared RV32I decode constants and the alucodesR32I operation-code macros used by aluR32I.
`ifndef ALUCODES_R32I_DEFS
`define ALUCODES_R32I_DEFS
`define ADD  4'd0
`define SUB  4'd1
`define SSL  4'd2
`define SLT  4'd3
`define SLTU 4'd4
`define XOR  4'd5
`define SSR  4'd6
`define SRA  4'd7
`define OR   4'd8
`define AND  4'd9
`endif

package r32i_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

endpackage

// File: rtl/operand_stage_r32i_if.sv
// Handshake, instruction, write-back and ALU-operand bundle of the operand stage.
interface operand_stage_r32i_if
    import r32i_pkg::*;
#(
    parameter int dataW = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic             wb_en;
    reg_idx_t         wb_rd;
    logic [dataW-1:0] wb_data;
    logic             out_valid;
    logic             out_ready;
    logic [dataW-1:0] A;
    logic [dataW-1:0] B;
    logic [3:0]       alucode;
    reg_idx_t         rd;
    logic             illegal;

    modport master (
        output in_valid, instr, wb_en, wb_rd, wb_data, out_ready,
        input  in_ready, out_valid, A, B, alucode, rd, illegal
    );

    modport slave (
        input  in_valid, instr, wb_en, wb_rd, wb_data, out_ready,
        output in_ready, out_valid, A, B, alucode, rd, illegal
    );
endinterface

// File: rtl/operand_stage_r32i_regfile.sv
// Integer register file: two combinational read ports, one write port, x0 hardwired to zero.
module regfile_r32i
    import r32i_pkg::*;
#(
    parameter int dataW = 32,
    parameter int regN  = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  reg_idx_t         rd_addr1,
    output logic [dataW-1:0] rd_data1,
    input  reg_idx_t         rd_addr2,
    output logic [dataW-1:0] rd_data2,
    input  logic             wr_en,
    input  reg_idx_t         wr_addr,
    input  logic [dataW-1:0] wr_data
);
    logic [dataW-1:0] regs_q [regN];
    logic [dataW-1:0] regs_d [regN];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && wr_addr != '0) regs_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < regN; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_data1 = (rd_addr1 == '0) ? '0 : regs_q[rd_addr1];
    assign rd_data2 = (rd_addr2 == '0) ? '0 : regs_q[rd_addr2];
endmodule

// File: rtl/operand_stage_r32i.sv
// Decode/operand-fetch stage ahead of aluR32I: decodes RV32I ALU ops, reads the register file, registers A/B/alucode/rd.
// Define WB_BYPASS_EN to forward a same-cycle write-back into the fetched operands.
module operand_stage_r32i
    import r32i_pkg::*;
#(
    parameter int dataW = 32,
    parameter int regN  = 32
) (
    input logic                 clock,
    input logic                 reset,
    operand_stage_r32i_if.slave bus
);
    logic [6:0]       opcode, funct7;
    logic [2:0]       funct3;
    reg_idx_t         rs1_idx, rs2_idx, rd_idx;
    logic [dataW-1:0] rf_rd1, rf_rd2, rs1_val, rs2_val;
    logic [dataW-1:0] imm_i, imm_u, shamt;
    logic             in_ready, take;

    logic             dec_ill;
    logic [dataW-1:0] dec_a, dec_b;
    logic [3:0]       dec_code;
    reg_idx_t         dec_rd;

    logic             out_valid_q, out_valid_d;
    logic [dataW-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       alucode_q, alucode_d;
    reg_idx_t         rd_q, rd_d;
    logic             illegal_q, illegal_d;

    assign opcode  = bus.instr[6:0];
    assign rd_idx  = bus.instr[11:7];
    assign funct3  = bus.instr[14:12];
    assign rs1_idx = bus.instr[19:15];
    assign rs2_idx = bus.instr[24:20];
    assign funct7  = bus.instr[31:25];
    assign imm_i   = {{(dataW-12){bus.instr[31]}}, bus.instr[31:20]};
    assign imm_u   = dataW'({bus.instr[31:12], 12'b0});
    assign shamt   = dataW'(bus.instr[24:20]);

    regfile_r32i #(.dataW(dataW), .regN(regN)) u_regfile (
        .clock    (clock),
        .reset    (reset),
        .rd_addr1 (rs1_idx),
        .rd_data1 (rf_rd1),
        .rd_addr2 (rs2_idx),
        .rd_data2 (rf_rd2),
        .wr_en    (bus.wb_en),
        .wr_addr  (bus.wb_rd),
        .wr_data  (bus.wb_data)
    );

    always_comb begin
        rs1_val = rf_rd1;
        rs2_val = rf_rd2;
`ifdef WB_BYPASS_EN
        // The file only updates at the edge, so a write racing this read is forwarded here.
        if (bus.wb_en && bus.wb_rd != '0 && bus.wb_rd == rs1_idx) rs1_val = bus.wb_data;
        if (bus.wb_en && bus.wb_rd != '0 && bus.wb_rd == rs2_idx) rs2_val = bus.wb_data;
`endif
    end

    always_comb begin
        dec_ill  = 1'b0;
        dec_a    = rs1_val;
        dec_b    = rs2_val;
        dec_code = `ADD;
        dec_rd   = rd_idx;
        case (opcode)
            OP_R: begin
                case ({funct7, funct3})
                    {F7_BASE, F3_ADD}:  dec_code = `ADD;
                    {F7_ALT,  F3_ADD}:  dec_code = `SUB;
                    {F7_BASE, F3_SLL}:  dec_code = `SSL;
                    {F7_BASE, F3_SLT}:  dec_code = `SLT;
                    {F7_BASE, F3_SLTU}: dec_code = `SLTU;
                    {F7_BASE, F3_XOR}:  dec_code = `XOR;
                    {F7_BASE, F3_SR}:   dec_code = `SSR;
                    {F7_ALT,  F3_SR}:   dec_code = `SRA;
                    {F7_BASE, F3_OR}:   dec_code = `OR;
                    {F7_BASE, F3_AND}:  dec_code = `AND;
                    default:            dec_ill  = 1'b1;
                endcase
            end
            OP_IMM: begin
                dec_b = imm_i;
                case (funct3)
                    F3_ADD:  dec_code = `ADD;
                    F3_SLT:  dec_code = `SLT;
                    F3_SLTU: dec_code = `SLTU;
                    F3_XOR:  dec_code = `XOR;
                    F3_OR:   dec_code = `OR;
                    F3_AND:  dec_code = `AND;
                    F3_SLL: begin
                        dec_b = shamt;
                        if (funct7 == F7_BASE) dec_code = `SSL;
                        else                   dec_ill  = 1'b1;
                    end
                    default: begin
                        dec_b = shamt;
                        if (funct7 == F7_BASE)     dec_code = `SSR;
                        else if (funct7 == F7_ALT) dec_code = `SRA;
                        else                       dec_ill  = 1'b1;
                    end
                endcase
            end
            OP_LUI: begin
                dec_a = '0;
                dec_b = imm_u;
            end
            default: dec_ill = 1'b1;
        endcase
        // Illegal words still travel down the pipe, but as a harmless ADD x0,0,0.
        if (dec_ill) begin
            dec_a    = '0;
            dec_b    = '0;
            dec_code = `ADD;
            dec_rd   = '0;
        end
    end

    assign in_ready = !out_valid_q || bus.out_ready;
    assign take     = bus.in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        a_d         = a_q;
        b_d         = b_q;
        alucode_d   = alucode_q;
        rd_d        = rd_q;
        illegal_d   = illegal_q;
        if (take) begin
            out_valid_d = 1'b1;
            a_d         = dec_a;
            b_d         = dec_b;
            alucode_d   = dec_code;
            rd_d        = dec_rd;
            illegal_d   = dec_ill;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            alucode_q   <= `ADD;
            rd_q        <= '0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            alucode_q   <= alucode_d;
            rd_q        <= rd_d;
            illegal_q   <= illegal_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.A         = a_q;
    assign bus.B         = b_q;
    assign bus.alucode   = alucode_q;
    assign bus.rd        = rd_q;
    assign bus.illegal   = illegal_q;
endmodule
